// File: rtl/tanh_act_pkg.sv
// Shared constants and types for the tanh activation input quantiser.
package tanh_act_pkg;

   localparam int ACT_W    = 4;
   localparam int ACT_MIN  = -8;
   localparam int ACT_MAX  = 7;
   localparam int SATCNT_W = 16;

   typedef logic signed [ACT_W-1:0] act_code_t;

endpackage

// File: rtl/tanh_in_quant_4bit_if.sv
// Streaming bus of the tanh input quantiser: accumulator words in, 4-bit codes out.
interface tanh_in_quant_4bit_if #(
   parameter int ACC_W = 16
);

   logic                            in_valid;
   logic                            in_ready;
   logic [ACC_W-1:0]                in_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [tanh_act_pkg::ACT_W-1:0]  out_data;
   logic                            out_sat;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/tanh_quant_stage.sv
// One-word valid/ready register slice; loads when empty or when its word leaves.
module tanh_quant_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/tanh_in_quant_4bit.sv
// Two-stage round/shift then saturate quantiser feeding the tanh In[3:0] bus.
// Optional saturation counter enabled by macro TANH_QUANT_SATCNT_EN.
module tanh_in_quant_4bit
   import tanh_act_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int SHIFT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   tanh_in_quant_4bit_if.slave  bus,
   input  logic                 sat_clr,
   output logic [SATCNT_W-1:0]  sat_count
);

   localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(2 ** (SHIFT-1));
   localparam logic signed [ACC_W:0] R_MIN = (ACC_W+1)'(ACT_MIN);
   localparam logic signed [ACC_W:0] R_MAX = (ACC_W+1)'(ACT_MAX);

   logic signed [ACC_W:0] rnd_sum;
   logic signed [ACC_W:0] r_in;
   logic signed [ACC_W:0] r_s1;
   logic [ACC_W:0]        s1_data;
   logic                  s1_in_ready;
   logic                  s1_valid;
   logic                  s2_in_ready;
   logic                  sat_lo;
   logic                  sat_hi;
   act_code_t             code;
   logic [ACT_W:0]        s2_data;
   logic                  s2_valid;

   // One extra bit of headroom keeps the rounding add from overflowing.
   always_comb begin
      rnd_sum = $signed({bus.in_data[ACC_W-1], bus.in_data}) + HALF;
      r_in    = rnd_sum >>> SHIFT;
   end

   tanh_quant_stage #(.W(ACC_W+1)) u_stage_round (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (s1_in_ready),
      .in_data   (r_in),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_data)
   );

   assign r_s1 = $signed(s1_data);

   always_comb begin
      sat_lo = r_s1 < R_MIN;
      sat_hi = r_s1 > R_MAX;
      code   = act_code_t'(r_s1[ACT_W-1:0]);
      if (sat_lo) begin
         code = act_code_t'(ACT_MIN);
      end else if (sat_hi) begin
         code = act_code_t'(ACT_MAX);
      end
   end

   tanh_quant_stage #(.W(ACT_W+1)) u_stage_sat (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   ({sat_lo || sat_hi, code}),
      .out_valid (s2_valid),
      .out_ready (bus.out_ready),
      .out_data  (s2_data)
   );

   assign bus.in_ready  = !rst && s1_in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data[ACT_W-1:0];
   assign bus.out_sat   = s2_data[ACT_W];

`ifdef TANH_QUANT_SATCNT_EN
   logic [SATCNT_W-1:0] sat_cnt_q;

   // Clear has priority over a same-cycle saturated transfer; count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || sat_clr) begin
         sat_cnt_q <= '0;
      end else if (s2_valid && bus.out_ready && s2_data[ACT_W] && (sat_cnt_q != '1)) begin
         sat_cnt_q <= sat_cnt_q + 1'b1;
      end
   end

   assign sat_count = sat_cnt_q;
`else
   logic sat_clr_unused;

   assign sat_clr_unused = sat_clr;
   assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_tanh_in_quant_4bit.sv
// Bench for tanh_in_quant_4bit: directed corner cases plus randomized traffic vs a real-arithmetic model.
module tb_tanh_in_quant_4bit;
   import tanh_act_pkg::*;

   localparam int ACC_W = 16;
   localparam int SHIFT = 4;
`ifdef TANH_QUANT_SATCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sat_clr = 1'b0;
   logic [15:0] sat_count;

   tanh_in_quant_4bit_if #(.ACC_W(ACC_W)) bus ();

   tanh_in_quant_4bit #(.ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cnt_model = 0;
   logic [4:0]  exp_q[$];
   logic [15:0] stim[$];
   bit          prev_stall = 1'b0;
   logic [3:0]  prev_data;
   logic        prev_sat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {sat, code}: floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamped to the code range.
   function automatic logic [4:0] ref_q(input logic [15:0] x);
      int          v;
      int          r;
      logic        sat;
      logic [31:0] c;
      v   = int'($signed(x));
      r   = $rtoi($floor((real'(v) + real'(2 ** (SHIFT-1))) / real'(2 ** SHIFT)));
      sat = (r < ACT_MIN) || (r > ACT_MAX);
      if (r < ACT_MIN)      c = ACT_MIN;
      else if (r > ACT_MAX) c = ACT_MAX;
      else                  c = r;
      return {sat, c[3:0]};
   endfunction

   function automatic logic [15:0] rnd_word();
      if ($urandom_range(0, 1) == 0) return 16'($urandom);
      return 16'($urandom_range(0, 400) - 200);
   endfunction

   task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy,
                        input logic clr, output logic acc);
      logic [4:0] e;
      logic       sat_xfer;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      sat_clr       = clr;
      #1;
      check("in_ready", bus.in_ready, (exp_q.size() < 2) || ordy);
      check("sat_count", sat_count, CNT_EN ? cnt_model : 0);
      if (prev_stall) begin
         check("hold_data", bus.out_data, prev_data);
         check("hold_sat", bus.out_sat, prev_sat);
      end
      sat_xfer = 1'b0;
      if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("out_valid_idle", bus.out_valid, 0);
         end else begin
            e = exp_q[0];
            check("out_data", bus.out_data, e[3:0]);
            check("out_sat", bus.out_sat, e[4]);
            if (ordy) begin
               void'(exp_q.pop_front());
               sat_xfer = e[4];
            end
         end
      end
      prev_stall = bus.out_valid && !ordy;
      prev_data  = bus.out_data;
      prev_sat   = bus.out_sat;
      acc = iv && bus.in_ready;
      if (acc) exp_q.push_back(ref_q(d));
      if (clr)                              cnt_model = 0;
      else if (sat_xfer && cnt_model < 65535) cnt_model++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      sat_clr       = 1'b0;
      #1;
      check("rst_in_ready_now", bus.in_ready, 0);
      @(negedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_sat", bus.out_sat, 0);
      check("rst_sat_count", sat_count, 0);
      check("rst_in_ready", bus.in_ready, 0);
      rst = 1'b0;
      exp_q.delete();
      cnt_model  = 0;
      prev_stall = 1'b0;
   endtask

   task automatic pump(input int unsigned max_cyc, input bit rnd);
      logic        acc;
      logic        iv;
      logic        ordy;
      logic [15:0] d;
      int unsigned n = 0;
      while ((stim.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
         iv   = (stim.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
         ordy = !rnd || ($urandom_range(0, 3) != 0);
         d    = 16'h0;
         if (iv) d = stim[0];
         cycle(iv, d, ordy, rnd && ($urandom_range(0, 15) == 0), acc);
         if (acc) void'(stim.pop_front());
         n++;
      end
      check("pump_drained", stim.size() + exp_q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc;
      int unsigned idx;
      logic [15:0] bp[4];

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      do_reset();

      // Two-cycle latency at full throughput.
      cycle(1'b1, 16'd24, 1'b1, 1'b0, acc);
      check("lat_accept", acc, 1);
      cycle(1'b0, 16'd0, 1'b1, 1'b0, acc);
      check("lat_c1_valid", bus.out_valid, 0);
      cycle(1'b0, 16'd0, 1'b1, 1'b0, acc);
      check("lat_c2_valid", bus.out_valid, 1);
      check("lat_c2_data", bus.out_data, 4'd2);
      check("lat_c2_sat", bus.out_sat, 0);

      // Rounding and saturation boundaries, back to back.
      stim = {16'd8, 16'd7, 16'hFFF8, 16'hFFF7, 16'h7FFF, 16'hFF38, 16'h8000,
              16'd119, 16'd120, 16'hFF78, 16'hFF77};
      pump(40, 1'b0);

      // Clear during a saturated transfer.
      cycle(1'b1, 16'h7FFF, 1'b0, 1'b0, acc);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, acc);
      cycle(1'b0, 16'h0, 1'b0, 1'b0, acc);
      cycle(1'b0, 16'h0, 1'b1, 1'b1, acc);
      cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
      check("clr_wins", sat_count, 0);

      // Backpressure: 1,2,3,4 after the shift.
      bp  = '{16'd16, 16'd32, 16'd48, 16'd64};
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         cycle(idx < 4, (idx < 4) ? bp[idx] : 16'h0, 1'b0, 1'b0, acc);
         if (acc) idx++;
         if (c >= 2) check("bp_hold", bus.out_data, 1);
      end
      check("bp_accepts", idx, 2);
      for (int unsigned i = idx; i < 4; i++) stim.push_back(bp[i]);
      pump(20, 1'b0);

      // Random traffic with random stalls and occasional clears.
      repeat (400) stim.push_back(rnd_word());
      pump(3000, 1'b1);

      // Reset with both stages full.
      cycle(1'b1, 16'h7FFF, 1'b0, 1'b0, acc);
      cycle(1'b1, 16'hFF38, 1'b0, 1'b0, acc);
      do_reset();
      cycle(1'b1, 16'd40, 1'b1, 1'b0, acc);
      pump(20, 1'b0);

`ifdef TANH_QUANT_SATCNT_EN
      repeat (65540) stim.push_back(16'h7FFF);
      pump(70000, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0, acc);
      check("cnt_sticky", sat_count, 16'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tanh_in_quant_4bit.md
TANH_IN_QUANT_4BIT -- requirements
Module: tanh_in_quant_4bit

Interface
REQ-001 Parameter ACC_W, default 16: width of the signed accumulator input word.
REQ-002 Parameter SHIFT, default 4, legal range 1..ACC_W-4: right-shift applied before rounding and saturation.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  the block accepts a word this cycle.
REQ-007 in_data  input  ACC_W  signed two's-complement accumulator value.
REQ-008 out_valid  output  1  out_data and out_sat are valid this cycle.
REQ-009 out_ready  input  1  the downstream tanh stage consumes the word this cycle.
REQ-010 out_data  output  4  4-bit two's-complement code, range -8..7; drives the tanh In[3:0] bus.
REQ-011 out_sat  output  1  this sample was clipped to -8 or 7.
REQ-012 sat_clr  input  1  synchronous clear of the saturation counter.
REQ-013 sat_count  output  16  running count of saturated samples.

Function
REQ-014 Transfer SHALL occur at the input when in_valid && in_ready, and at the output when out_valid && out_ready.
REQ-015 Stage 1 SHALL compute r = (in_data + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round-half-up) at ACC_W+1 bits so no overflow occurs.
REQ-016 Stage 2 SHALL saturate r to [-8, 7]. out_sat=1 iff r<-8 or r>7; otherwise out_data=r[3:0].
REQ-017 Each stage SHALL hold one word with its own valid bit; latency in_data to out_data SHALL be 2 cycles with no stall.
REQ-018 A stage SHALL load whenever it is empty or its content is leaving in the same cycle. in_ready = !v1 || (!v2 || out_ready).
REQ-019 Throughput SHALL be one word per cycle while out_ready=1; no bubbles shall be inserted.
REQ-020 With out_ready=0 and both stages full, in_ready SHALL be 0. out_data and out_sat SHALL hold stable while out_valid && !out_ready.
REQ-021 sat_count SHALL increment by 1 on each output transfer with out_sat=1, and SHALL stick at 0xFFFF without wrapping.
REQ-022 On simultaneous sat_clr and a saturated output transfer, the counter SHALL load 0; sat_clr wins.
REQ-023 in_ready SHALL have no combinational path from in_valid. It MAY depend combinationally on out_ready.

Reset
REQ-024 While rst=1: v1=v2=0, out_valid=0, out_data=0, out_sat=0, sat_count=0, and in_ready=0 for that cycle.
REQ-025 Reset mid-operation SHALL discard both in-flight words. No out_valid SHALL be asserted in the cycle after reset deasserts.

Configuration
REQ-026 Macro TANH_QUANT_SATCNT_EN defined: the saturation counter and sat_clr SHALL be implemented as in REQ-021/022.
REQ-027 Macro TANH_QUANT_SATCNT_EN undefined: sat_count SHALL be tied to 0, sat_clr SHALL be ignored, and no counter flops SHALL exist. out_sat behaviour is unchanged.

Structure
REQ-028 Package tanh_act_pkg SHALL hold: the constants ACT_W=4, ACT_MIN=-8, ACT_MAX=7, SATCNT_W=16; and the typedef act_code_t (signed 4-bit).
REQ-029 Sub-module tanh_quant_stage (one valid/ready register slice, parameterised data width) SHALL be instantiated twice.

Verification
REQ-030 SHIFT=4, out_ready=1: in_data=24 -> out_data=2, out_sat=0, two cycles later.
REQ-031 SHIFT=4: in_data=0x7FFF -> out_data=7, out_sat=1, sat_count +1. in_data=-200 -> out_data=-8 (0x8), out_sat=1.
REQ-032 Rounding boundaries, SHIFT=4: in_data=8 -> 1; in_data=7 -> 0; in_data=-8 -> 0; in_data=-9 -> -1 (0xF).
REQ-033 Backpressure: stream 1,2,3,4 (after shift) with out_ready=0 for 5 cycles. in_ready SHALL drop after 2 accepts, out_data SHALL hold 1, and the full sequence SHALL emit in order with no loss or duplication.
REQ-034 Assert rst with both stages full: out_valid=0 next cycle and sat_count=0. Drive sat_clr with a saturated transfer in the same cycle -> sat_count=0. Preload 0xFFFF then saturate -> count stays 0xFFFF.
